// File: rtl/sqrt_controller_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared constants and the FSM state type for the integer square-root
// controller. Widths derive from the radicand width; the comparator width is
// fixed at 17 bits, which is why only a 16-bit radicand is supported.
// -----------------------------------------------------------------------------
package sqrt_pkg;

  localparam int DATA_W  = 16;            // radicand width
  localparam int ROOT_W  = DATA_W / 2;    // root width
  localparam int REM_W   = DATA_W / 2 + 1;// remainder width
  localparam int CMP_W   = 17;            // fixed comparator operand width
  localparam int N_ITER  = DATA_W / 2;    // one root bit per iteration
  localparam int CNT_W   = $clog2(N_ITER);
  localparam int REMSH_W = REM_W + 2;     // remainder with next radicand pair
  localparam int TRIAL_W = ROOT_W + 2;    // (root << 2) | 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage : sqrt_pkg

// File: rtl/sqrt_controller_if.sv
// -----------------------------------------------------------------------------
// sqrt_controller_if
// Start/done handshake bundle between the requester and the sqrt controller.
//   start_i      requester -> controller : request a computation
//   radicand_i   requester -> controller : operand, captured on acceptance
//   busy_o       controller -> requester : operation in progress
//   done_o       controller -> requester : one-cycle result-valid pulse
//   root_o       controller -> requester : floor(sqrt(radicand))
//   remainder_o  controller -> requester : radicand - root^2
// -----------------------------------------------------------------------------
interface sqrt_controller_if;
  import sqrt_pkg::*;

  logic              start_i;
  logic [DATA_W-1:0] radicand_i;
  logic              busy_o;
  logic              done_o;
  logic [ROOT_W-1:0] root_o;
  logic [REM_W-1:0]  remainder_o;

  // Requester side.
  modport master (
    output start_i,
    output radicand_i,
    input  busy_o,
    input  done_o,
    input  root_o,
    input  remainder_o
  );

  // Controller side.
  modport slave (
    input  start_i,
    input  radicand_i,
    output busy_o,
    output done_o,
    output root_o,
    output remainder_o
  );

endinterface : sqrt_controller_if

// File: rtl/sqrt_controller_comparator.sv
// -----------------------------------------------------------------------------
// Comparator
// Unsigned 17-bit magnitude comparator used by the sqrt datapath.
//   A_i              in  17 : left operand
//   B_i              in  17 : right operand
//   A_less_than_B_o  out 1  : 1 when A_i < B_i (unsigned)
// -----------------------------------------------------------------------------
module Comparator (
  input  logic [sqrt_pkg::CMP_W-1:0] A_i,
  input  logic [sqrt_pkg::CMP_W-1:0] B_i,
  output logic                       A_less_than_B_o
);

  assign A_less_than_B_o = (A_i < B_i);

endmodule : Comparator

// File: rtl/sqrt_controller.sv
// -----------------------------------------------------------------------------
// sqrt_controller
// Restoring digit-by-digit integer square root: one root bit per ITER cycle,
// decided by a single shared comparator. Start is accepted only in IDLE;
// results are registered in DONE and held until the next DONE.
//   clk_i  in  1 : clock, rising edge
//   rst_i  in  1 : synchronous active-high reset
//   bus    slave : start/radicand in, busy/done/root/remainder out
// -----------------------------------------------------------------------------
module sqrt_controller #(
  parameter int DATA_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sqrt_controller_if.slave   bus
);
  import sqrt_pkg::*;

  // The comparator is fixed at 17 bits, so no other radicand width can work.
  if (DATA_W != sqrt_pkg::DATA_W) begin : g_width_check
    $error("sqrt_controller: DATA_W must be 16");
  end

  sqrt_state_t        r_state;
  sqrt_state_t        w_state_next;

  logic [DATA_W-1:0]  r_shift;      // radicand pairs still to consume, MSB first
  logic [REM_W-1:0]   r_rem;
  logic [ROOT_W-1:0]  r_root;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_busy;
  logic               r_done;
  logic [ROOT_W-1:0]  r_root_out;
  logic [REM_W-1:0]   r_rem_out;

  logic [REMSH_W-1:0] w_rem_sh;
  logic [TRIAL_W-1:0] w_trial;
  logic [CMP_W-1:0]   w_cmp_a;
  logic [CMP_W-1:0]   w_cmp_b;
  logic               w_lt;
  logic [REM_W-1:0]   w_rem_next;
  logic [ROOT_W-1:0]  w_root_next;

  assign w_cmp_a = CMP_W'(w_rem_sh);
  assign w_cmp_b = CMP_W'(w_trial);

  Comparator u_cmp (
    .A_i             (w_cmp_a),
    .B_i             (w_cmp_b),
    .A_less_than_B_o (w_lt)
  );

  // Next-state and one iteration of the root recurrence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_rem_sh     = {r_rem, r_shift[DATA_W-1 -: 2]};
    w_trial      = {r_root, 2'b01};
    w_rem_next   = r_rem;
    w_root_next  = r_root;

    if (w_lt) begin
      // Trial too large: root bit is 0, remainder just absorbs the pair.
      w_rem_next  = REM_W'(w_rem_sh);
      w_root_next = {r_root[ROOT_W-2:0], 1'b0};
    end else begin
      // rem_sh >= trial, so the difference fits and never underflows.
      w_rem_next  = REM_W'(w_rem_sh - REMSH_W'(w_trial));
      w_root_next = {r_root[ROOT_W-2:0], 1'b1};
    end

    unique case (r_state)
      IDLE:    if (bus.start_i) w_state_next = ITER;
      ITER:    if (r_cnt == CNT_W'(N_ITER - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_root_out <= '0;
      r_rem_out  <= '0;
    end else begin
      r_state <= w_state_next;
      // busy reflects the state that was active at this edge, so it rises one
      // cycle after acceptance and stays high through the DONE cycle.
      r_busy  <= (r_state != IDLE);
      r_done  <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (bus.start_i) begin
            r_shift <= bus.radicand_i;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
          end
        end
        ITER: begin
          r_shift <= {r_shift[DATA_W-3:0], 2'b00};
          r_rem   <= w_rem_next;
          r_root  <= w_root_next;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_root_out <= r_root;
          r_rem_out  <= r_rem;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.root_o      = r_root_out;
  assign bus.remainder_o = r_rem_out;

endmodule : sqrt_controller

// File: tb/tb_sqrt_controller.sv
// -----------------------------------------------------------------------------
// tb_sqrt_controller
// Self-checking bench for sqrt_controller. Expected roots come from a plain
// arithmetic model (largest r with r*r <= x); cycle timing is checked against
// the accept edge. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sqrt_controller;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  sqrt_controller_if bus ();

  sqrt_controller #(
    .DATA_W (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Reference model: integer square root by search.
  function automatic void ref_sqrt(input int x, output int r, output int rm);
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    rm = x - r * r;
  endfunction

  // Accept one operand and check busy/done timing over 10 cycles plus result.
  task automatic run_and_check(input logic [15:0] x);
    int   er;
    int   erem;
    logic exp_done;
    logic exp_busy;
    ref_sqrt(int'(x), er, erem);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.radicand_i = x;
    @(negedge clk);                       // accept edge N has passed
    bus.start_i    = 1'b0;
    bus.radicand_i = 16'($urandom);       // must not disturb the operation
    n_tests++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_at_accept x=%0d: got %b expected 0", x, bus.busy_o);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_done = (c == 9);
      exp_busy = (c <= 9);
      n_tests++;
      if (bus.done_o !== exp_done) begin
        n_fail++;
        $display("FAIL done_timing x=%0d cyc=N+%0d: got %b expected %b", x, c, bus.done_o, exp_done);
      end
      n_tests++;
      if (bus.busy_o !== exp_busy) begin
        n_fail++;
        $display("FAIL busy_timing x=%0d cyc=N+%0d: got %b expected %b", x, c, bus.busy_o, exp_busy);
      end
    end
    n_tests++;
    if (bus.root_o !== 8'(er)) begin
      n_fail++;
      $display("FAIL root x=%0d: got %0d expected %0d", x, bus.root_o, er);
    end
    n_tests++;
    if (bus.remainder_o !== 9'(erem)) begin
      n_fail++;
      $display("FAIL remainder x=%0d: got %0d expected %0d", x, bus.remainder_o, erem);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start_i    = 1'b1;
    bus.radicand_i = 16'd144;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    n_tests++;
    if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    n_tests++;
    if (bus.root_o !== 8'd0) begin n_fail++; $display("FAIL reset_root: got %0d expected 0", bus.root_o); end
    n_tests++;
    if (bus.remainder_o !== 9'd0) begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", bus.remainder_o); end
    bus.start_i = 1'b0;
    rst         = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_values();
    run_and_check(16'd144);
    run_and_check(16'd65535);
    run_and_check(16'd0);
    run_and_check(16'd1);
    run_and_check(16'd200);
  endtask

  task automatic test_boundaries();
    logic [15:0] vals [10];
    vals = '{16'd2, 16'd3, 16'd4, 16'd255, 16'd256, 16'd65024,
             16'd65025, 16'd65534, 16'd16383, 16'd16384};
    foreach (vals[i]) run_and_check(vals[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) run_and_check(16'($urandom));
  endtask

  // Starts seen in ITER and DONE must be dropped, not queued.
  task automatic test_ignored_start();
    int   dones;
    logic exp_done;
    logic exp_busy;
    dones = 0;
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.radicand_i = 16'd200;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      bus.start_i    = (c == 4) || (c == 9);
      bus.radicand_i = 16'd9;
      @(negedge clk);
      exp_done = (c == 9);
      exp_busy = (c <= 9);
      if (bus.done_o === 1'b1) dones++;
      n_tests++;
      if (bus.done_o !== exp_done) begin
        n_fail++;
        $display("FAIL ignored_start_done cyc=N+%0d: got %b expected %b", c, bus.done_o, exp_done);
      end
      n_tests++;
      if (bus.busy_o !== exp_busy) begin
        n_fail++;
        $display("FAIL ignored_start_busy cyc=N+%0d: got %b expected %b", c, bus.busy_o, exp_busy);
      end
    end
    bus.start_i = 1'b0;
    n_tests++;
    if (dones != 1) begin n_fail++; $display("FAIL ignored_start_count: got %0d expected 1", dones); end
    n_tests++;
    if (bus.root_o !== 8'd14) begin n_fail++; $display("FAIL ignored_start_root: got %0d expected 14", bus.root_o); end
    n_tests++;
    if (bus.remainder_o !== 9'd4) begin n_fail++; $display("FAIL ignored_start_rem: got %0d expected 4", bus.remainder_o); end
  endtask

  // Reset mid-iteration aborts with no done pulse and clears held results.
  task automatic test_reset_abort();
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.radicand_i = 16'd50000;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      rst = (c == 6);
      @(negedge clk);
      n_tests++;
      if (bus.done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_done cyc=N+%0d: got %b expected 0", c, bus.done_o);
      end
      if (c >= 6) begin
        n_tests++;
        if (bus.busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_busy cyc=N+%0d: got %b expected 0", c, bus.busy_o);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (bus.root_o !== 8'd0) begin n_fail++; $display("FAIL abort_root: got %0d expected 0", bus.root_o); end
        n_tests++;
        if (bus.remainder_o !== 9'd0) begin n_fail++; $display("FAIL abort_rem: got %0d expected 0", bus.remainder_o); end
      end
    end
    rst = 1'b0;
    run_and_check(16'd49);
  endtask

  // Reset and start on the same edge: reset wins, start is dropped.
  task automatic test_reset_start_collision();
    @(negedge clk);
    rst            = 1'b1;
    bus.start_i    = 1'b1;
    bus.radicand_i = 16'd1000;
    @(negedge clk);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    n_tests++;
    if (bus.root_o !== 8'd0) begin n_fail++; $display("FAIL collision_root: got %0d expected 0", bus.root_o); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL collision_busy cyc=%0d: got %b expected 0", c, bus.busy_o);
      end
      n_tests++;
      if (bus.done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL collision_done cyc=%0d: got %b expected 0", c, bus.done_o);
      end
    end
  endtask

  // start held high: one acceptance every 10 cycles, operand taken at accept.
  task automatic test_back_to_back();
    logic [15:0] q [$];
    logic [15:0] x;
    logic        exp_done;
    logic        exp_busy;
    int          er;
    int          erem;
    @(negedge clk);
    bus.start_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      x              = 16'($urandom);
      bus.radicand_i = x;
      if (c % 10 == 0) q.push_back(x);
      @(negedge clk);
      exp_done = (c % 10 == 9);
      exp_busy = (c % 10 != 0);
      n_tests++;
      if (bus.done_o !== exp_done) begin
        n_fail++;
        $display("FAIL b2b_done cyc=N+%0d: got %b expected %b", c, bus.done_o, exp_done);
      end
      n_tests++;
      if (bus.busy_o !== exp_busy) begin
        n_fail++;
        $display("FAIL b2b_busy cyc=N+%0d: got %b expected %b", c, bus.busy_o, exp_busy);
      end
      if (exp_done && q.size() > 0) begin
        x = q.pop_front();
        ref_sqrt(int'(x), er, erem);
        n_tests++;
        if (bus.root_o !== 8'(er)) begin
          n_fail++;
          $display("FAIL b2b_root x=%0d: got %0d expected %0d", x, bus.root_o, er);
        end
        n_tests++;
        if (bus.remainder_o !== 9'(erem)) begin
          n_fail++;
          $display("FAIL b2b_rem x=%0d: got %0d expected %0d", x, bus.remainder_o, erem);
        end
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.radicand_i = '0;

    test_reset();
    test_known_values();
    test_boundaries();
    test_random();
    test_ignored_start();
    test_reset_abort();
    test_reset_start_collision();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sqrt_controller
